dec_scan_seq: RTL and testbench
===============================

# dec_scan_seq

Sequencer that drives the address `w[3:0]` and enable `e` inputs of the 4-to-16 one-hot decoder stage. It sweeps a programmable address range, up or down, holding each address for a programmable number of cycles, in single-sweep or continuous mode, with pause and abort control. It is the upstream stage of the decoder; its `w`/`e` outputs connect directly to the decoder's `w`/`e` inputs.

## Interface
- `DWELL_W`, default 4: width of the dwell count.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a sweep; sampled only in IDLE.
- `pause` input 1: level; freezes the sweep and drops `e` while high.
- `abort` input 1: terminates the sweep from any state.
- `continuous` input 1: 1 = wrap from `last` to `first` indefinitely; 0 = single sweep. Latched at start.
- `dir` input 1: 0 = increment, 1 = decrement. Latched at start.
- `first` input 4: first address of the sweep. Latched at start.
- `last` input 4: last address of the sweep. Latched at start.
- `dwell` input DWELL_W: cycles per address. Latched at start; 0 is treated as 1.
- `w` output 4: decoder address (registered).
- `e` output 1: decoder enable (registered).
- `busy` output 1: high in RUN and PAUSE.
- `done` output 1: one-cycle pulse at single-sweep completion.
- `wrap` output 1: one-cycle pulse when continuous mode reloads `first`.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE.
- **Reset:** state IDLE; `w`=0, `e`=0, `busy`=0, `done`=0, `wrap`=0; dwell counter 0.
- **IDLE:**
  - `start`=1 latches `first`, `last`, `dir`, `continuous`, and D=max(`dwell`,1).
  - Loads `w`=`first` and `e`=1, clears the dwell counter, goes to RUN.
  - `w` keeps its last value while idle.
- **RUN:**
  - The dwell counter increments every cycle.
  - When the current address has been enabled for D cycles, the address advances.
  - Advance when `w`≠`last`: `w`=`w`+1 if `dir`=0, else `w`−1, both mod 16. Example: `first`=14, `last`=1, up gives 14,15,0,1.
  - Advance when `w`=`last` and `continuous`=1: `w`=`first`, `wrap`=1 for one cycle.
  - Advance when `w`=`last` and `continuous`=0: `e`=0, go to DONE.
- **Sweep length:** N = ((`last`−`first`) mod 16)+1 for up, and ((`first`−`last`) mod 16)+1 for down. `first`=`last` gives N=1.
- **PAUSE:**
  - Entered from RUN when `pause`=1. `e`=0; `w` and the dwell counter are held.
  - `pause`=0 returns to RUN with `e`=1, and the remaining dwell continues.
  - `pause` has priority over an advance in the same cycle; the advance is deferred until RUN resumes.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- **abort:**
  - Highest priority after `rst`; from any state goes to IDLE next cycle.
  - `e`=0, `busy`=0, no `done` or `wrap` pulse, `w` held.
- **Ignored inputs:** `start` outside IDLE. `pause` in IDLE and DONE. Changes to the latched inputs mid-sweep.
- **Decoder output:** at most one decoder output is active per cycle; `e`=0 whenever `busy`=0.

## Timing
- **Start:** `start` sampled at edge t gives `w`=`first`, `e`=1, `busy`=1 from t+1.
- **Per address:** each address is presented for exactly D enabled cycles, with no gap cycle between addresses.
- **Single sweep:**
  - `e`=1 for cycles t+1 … t+N·D.
  - At t+N·D+1: `e`=0, `busy`=0, `done`=1.
  - IDLE from t+N·D+2, which is the earliest accepted `start`.
- **Continuous:** `wrap` is high in the same cycle that `w` first shows `first` again.
- **Pause:** `pause` sampled high at edge p gives `e`=0 from p+1. Deassertion sampled at edge q gives `e`=1 from q+1.
- **Abort:** `abort` at edge a gives `e`=0 and `busy`=0 from a+1.
- **Reset:** `rst` overrides everything at the edge, including mid-sweep.

## Structure
- **Package `dec_scan_pkg`:** state enum (IDLE, RUN, PAUSE, DONE) and `ADDR_W`=4.
- **Sub-module `dwell_timer`:**
  - Parameterised by DWELL_W.
  - Inputs: load, hold, D. Output: `expire`, asserted on the D-th enabled cycle.
  - Instantiated once.
- **Top level:** FSM, address register, and the latched configuration register.

## Test plan
- **Single up sweep:** `first`=2, `last`=5, `dwell`=1, `continuous`=0, `dir`=0 → `w`=2,3,4,5 with `e`=1 for 4 cycles; `done` pulse on the 5th cycle; `busy` drops with it.
- **Down sweep across zero:** `first`=1, `last`=14, `dir`=1, `dwell`=2 → `w`=1,1,0,0,15,15,14,14, then `done`.
- **Continuous mode:** `first`=3, `last`=4, `dwell`=3 → sequence 3×3, 4×3, then `wrap`=1 with `w`=3; repeats until `abort`. After `abort`, `e`=0 next cycle and no `done`.
- **Pause mid-dwell:**
  - `dwell`=4; assert `pause` after 2 cycles on address 7 for 5 cycles.
  - `e`=0 for those 5 cycles, then address 7 is enabled for 2 more cycles before advancing.
  - Assert `pause` on the advance cycle → address is held.
- **Edge inputs:**
  - `dwell`=0 behaves as 1.
  - `first`=`last`=9 → `w`=9 for one cycle, then `done`.
  - `start` during RUN is ignored.
- **Reset mid-sweep:** `rst`=1 while in RUN with `w`=6 → next cycle `w`=0, `e`=0, `busy`=0, state IDLE.

Source files
------------

// File: rtl/dec_scan_pkg.sv
// Shared types for the decoder scan sequencer: FSM states, latched sweep
// configuration and the address stepping helper.
package dec_scan_pkg;

    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
        logic              dir;
        logic              cont;
    } cfg_t;

    // Addresses wrap mod 2^ADDR_W in both directions
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a,
                                                    input logic              down);
        return down ? (a - ADDR_W'(1)) : (a + ADDR_W'(1));
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts enabled cycles on the current address; expire flags the D-th one.
module dwell_timer
    import dec_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               hold,
    input  logic [DWELL_W-1:0] d,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= cnt + DWELL_W'(1);
        end
    end

    // d is never zero here, so d-1 is the index of the final dwell cycle
    assign expire = (cnt == (d - DWELL_W'(1)));

endmodule

// File: rtl/dec_scan_seq.sv
// Sweeps the 4-to-16 decoder address range, holding each address for a
// programmable dwell, with pause, abort, single-sweep and continuous modes.
module dec_scan_seq
    import dec_scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    input  logic               continuous,
    input  logic               dir,
    input  logic [ADDR_W-1:0]  first,
    input  logic [ADDR_W-1:0]  last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0]  w,
    output logic               e,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    state_t             state_q, state_d;
    cfg_t               cfg_q;
    logic [DWELL_W-1:0] d_q;
    logic [ADDR_W-1:0]  w_d;
    logic               e_d, wrap_d;
    logic               load, hold, expire, adv, cfg_ld;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .hold   (hold),
        .d      (d_q),
        .expire (expire)
    );

    // A pause landing on the final dwell cycle freezes the count at expiry so
    // the deferred advance fires on resume without an extra enabled cycle.
    assign hold = (state_q != RUN) || (pause && expire);

    assign busy = (state_q == RUN) || (state_q == PAUSE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w       <= '0;
            e       <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            w       <= w_d;
            e       <= e_d;
            wrap    <= wrap_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_ld) begin
            cfg_q <= '{first: first, last: last, dir: dir, cont: continuous};
            d_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w;
        e_d     = e;
        wrap_d  = 1'b0;
        load    = 1'b0;
        cfg_ld  = 1'b0;
        adv     = 1'b0;
        if (abort) begin
            state_d = IDLE;
            e_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    e_d = 1'b0;
                    if (start) begin
                        cfg_ld  = 1'b1;
                        load    = 1'b1;
                        w_d     = first;
                        e_d     = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                        e_d     = 1'b0;
                    end else if (expire) begin
                        adv = 1'b1;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        if (expire) begin
                            adv = 1'b1;
                        end else begin
                            state_d = RUN;
                            e_d     = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    e_d     = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    e_d     = 1'b0;
                end
            endcase

            if (adv) begin
                load = 1'b1;
                if (w != cfg_q.last) begin
                    w_d     = step_addr(w, cfg_q.dir);
                    e_d     = 1'b1;
                    state_d = RUN;
                end else if (cfg_q.cont) begin
                    w_d     = cfg_q.first;
                    wrap_d  = 1'b1;
                    e_d     = 1'b1;
                    state_d = RUN;
                end else begin
                    e_d     = 1'b0;
                    state_d = DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Scoreboard bench for dec_scan_seq: expected per-cycle outputs are queued
// with the stimulus and compared on the falling edge.
module tb_dec_scan_seq;

    typedef struct packed {
        logic [3:0] w;
        logic       e;
        logic       busy;
        logic       done;
        logic       wrap;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst, start, pause, abort, continuous, dir;
    logic [3:0] first, last, dwell;
    logic [3:0] w;
    logic       e, busy, done, wrap;

    int   passed = 0;
    int   total  = 0;
    obs_t exp_q[$];

    dec_scan_seq #(.DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .continuous (continuous),
        .dir        (dir),
        .first      (first),
        .last       (last),
        .dwell      (dwell),
        .w          (w),
        .e          (e),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic push(input int pw, input int pe, input int pb, input int pd, input int pr);
        obs_t x;
        x.w    = 4'(pw);
        x.e    = 1'(pe);
        x.busy = 1'(pb);
        x.done = 1'(pd);
        x.wrap = 1'(pr);
        exp_q.push_back(x);
    endtask

    task automatic begin_sweep(input int f, input int l, input int dr, input int c, input int dw);
        first      = 4'(f);
        last       = 4'(l);
        dir        = 1'(dr);
        continuous = 1'(c);
        dwell      = 4'(dw);
        start      = 1'b1;
    endtask

    task automatic test_reset();
        obs_t ex, got;
        rst = 1'b1; start = 1'b1; first = 4'd7; last = 4'd9; dwell = 4'd2;
        push(0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL reset k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
        rst = 1'b0; start = 1'b0;
    endtask

    task automatic test_single_up();
        obs_t ex, got;
        begin_sweep(2, 5, 0, 0, 1);
        for (int a = 2; a <= 5; a++) push(a, 1, 1, 0, 0);
        push(5, 0, 0, 1, 0);
        push(5, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) begin start = 1'b0; first = 4'd0; last = 4'd0; dir = 1'b1; end
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL single_up k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    task automatic test_down_zero();
        obs_t ex, got;
        int   seq[4] = '{1, 0, 15, 14};
        begin_sweep(1, 14, 1, 0, 2);
        foreach (seq[i]) begin
            push(seq[i], 1, 1, 0, 0);
            push(seq[i], 1, 1, 0, 0);
        end
        push(14, 0, 0, 1, 0);
        push(14, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL down_zero k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    task automatic test_continuous();
        obs_t ex, got;
        begin_sweep(3, 4, 0, 1, 3);
        for (int r = 0; r < 2; r++) begin
            push(3, 1, 1, 0, (r == 0) ? 0 : 1);
            push(3, 1, 1, 0, 0);
            push(3, 1, 1, 0, 0);
            for (int i = 0; i < 3; i++) push(4, 1, 1, 0, 0);
        end
        push(3, 1, 1, 0, 1);
        push(3, 0, 0, 0, 0);
        push(3, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) begin start = 1'b0; continuous = 1'b0; end
            if (k == 12) abort = 1'b1;
            if (k == 13) abort = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL continuous k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    task automatic test_pause();
        obs_t ex, got;
        begin_sweep(6, 9, 0, 0, 4);
        for (int i = 0; i < 4; i++) push(6, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) push(7, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) push(7, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) push(7, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) push(8, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) push(8, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) push(9, 1, 1, 0, 0);
        push(9, 0, 0, 1, 0);
        push(9, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0)  start = 1'b0;
            if (k == 5)  pause = 1'b1;
            if (k == 10) pause = 1'b0;
            if (k == 16) pause = 1'b1;
            if (k == 18) pause = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL pause k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    task automatic test_edges();
        obs_t ex, got;
        begin_sweep(9, 9, 0, 0, 0);
        push(9, 1, 1, 0, 0);
        push(9, 0, 0, 1, 0);
        push(9, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL edge_single k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
        begin_sweep(0, 2, 0, 0, 2);
        for (int a = 0; a <= 2; a++) begin
            push(a, 1, 1, 0, 0);
            push(a, 1, 1, 0, 0);
        end
        push(2, 0, 0, 1, 0);
        push(2, 0, 0, 0, 0);
        push(2, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) begin first = 4'd10; last = 4'd10; end
            if (k == 1) start = 1'b0;
            if (k == 6) begin start = 1'b1; first = 4'd12; last = 4'd12; end
            if (k == 7) start = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL edge_start_ignored k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t ex, got;
        begin_sweep(4, 10, 0, 0, 2);
        push(4, 1, 1, 0, 0);
        push(4, 1, 1, 0, 0);
        push(5, 1, 1, 0, 0);
        push(5, 1, 1, 0, 0);
        push(6, 1, 1, 0, 0);
        push(0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 5) rst = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL reset_mid k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t ex, got;
        begin_sweep(2, 3, 0, 0, 1);
        push(2, 1, 1, 0, 0);
        push(3, 1, 1, 0, 0);
        push(3, 0, 0, 1, 0);
        push(3, 0, 0, 0, 0);
        push(5, 1, 1, 0, 0);
        push(5, 0, 0, 1, 0);
        push(5, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 3) begin_sweep(5, 5, 0, 0, 1);
            if (k == 4) start = 1'b0;
            ex  = exp_q.pop_front();
            got = {w, e, busy, done, wrap};
            total++;
            if (got !== ex)
                $display("FAIL back_to_back k=%0d: got w=%0d e=%b busy=%b done=%b wrap=%b, expected w=%0d e=%b busy=%b done=%b wrap=%b",
                         k, got.w, got.e, got.busy, got.done, got.wrap, ex.w, ex.e, ex.busy, ex.done, ex.wrap);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        continuous = 1'b0; dir = 1'b0; first = 4'd0; last = 4'd0; dwell = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single_up();
        test_down_zero();
        test_continuous();
        test_pause();
        test_edges();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
